cntl_mc_param: RTL and testbench

- Parametrised multi-cycle RISC-V RV32I control FSM; next generation of the team's multi-cycle controller.
- Drives the same datapath control signals as before, and adds:
  - a memory ready handshake, with any number of wait cycles per access;
  - illegal-instruction trap;
  - retired-instruction counter;
  - parametrised ALU control width.
- Sits between the instruction register/memory and the multi-cycle datapath.

---
 rtl/cntl_mc_param.sv | 265 ++++++++++++++++++++++++++
 tb/tb_cntl_mc_param.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cntl_mc_param.sv
// Multi-cycle RV32I control FSM with memory ready handshake, illegal-instruction trap and
// retired-instruction counter. Defining CNTL_MC_MULDIV_EN adds the MULDIV dispatch path.
module cntl_mc_param #(
  parameter int unsigned ALU_CTRL_WIDTH  = 5,
  parameter int unsigned CNT_WIDTH       = 32,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               instruction,
  input  logic                      bcond,
  input  logic                      mem_ready,
  input  logic                      md_done,
  output logic                      i_d_mem,
  output logic                      mem_r,
  output logic                      mem_w,
  output logic                      op1_sel,
  output logic [1:0]                op2_sel,
  output logic [1:0]                alu_demux,
  output logic                      wr_reg_mux,
  output logic                      wr_en,
  output logic                      load_ir,
  output logic                      pc_update,
  output logic                      load_mdr,
  output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl,
  output logic [1:0]                mem_size,
  output logic                      md_start,
  output logic                      trap,
  output logic [CNT_WIDTH-1:0]      instret
);

  typedef enum logic [4:0] {
    StFetch, StDecode, StExecR, StExecI, StExecU, StWb, StAddr, StMemRd, StWbLd, StMemWr,
    StBranch, StBrTaken, StLink, StJump, StTrap, StMulDiv
  } state_e;

  localparam logic [4:0] OpLoad   = 5'b00000;
  localparam logic [4:0] OpImm    = 5'b00100;
  localparam logic [4:0] OpAuipc  = 5'b00101;
  localparam logic [4:0] OpStore  = 5'b01000;
  localparam logic [4:0] OpReg    = 5'b01100;
  localparam logic [4:0] OpLui    = 5'b01101;
  localparam logic [4:0] OpBranch = 5'b11000;
  localparam logic [4:0] OpJalr   = 5'b11001;
  localparam logic [4:0] OpJal    = 5'b11011;

  state_e               state_q, state_d, dec_state;
  logic [4:0]           alu_code_q, alu_code_d, dec_code;
  logic [1:0]           mem_size_q, mem_size_d, dec_size;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic                 dec_legal, retire;

  logic [4:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = instruction[6:2];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  // Register-index and immediate fields belong to the datapath.
  logic unused_inst;
  assign unused_inst = ^{instruction[24:15], instruction[11:7]};

  always_comb begin
    dec_legal = (instruction[1:0] == 2'b11);
    dec_state = StTrap;
    dec_code  = 5'b00000;
    dec_size  = 2'b00;
    case (opcode)
      OpReg: begin
        if (funct7 == 7'b0000001) begin
`ifdef CNTL_MC_MULDIV_EN
          dec_state = StMulDiv;
`else
          dec_legal = 1'b0;
`endif
        end else begin
          dec_state = StExecR;
          dec_code  = {1'b0, instruction[30], funct3};
        end
      end
      OpImm: begin
        dec_state = StExecI;
        if (funct3 == 3'b010 || funct3 == 3'b011) dec_code = {2'b01, funct3};
        else if (funct3 == 3'b101)                dec_code = {1'b0, instruction[30], funct3};
        else                                      dec_code = {2'b00, funct3};
      end
      OpLui: begin
        dec_state = StExecU;
        dec_code  = 5'b11000;
      end
      OpAuipc:          dec_state = StExecU;
      OpLoad, OpStore: begin
        dec_state = StAddr;
        dec_size  = funct3[1:0];
      end
      OpBranch: begin
        dec_state = StBranch;
        dec_code  = {2'b10, funct3};
      end
      OpJal, OpJalr:    dec_state = StLink;
      default:          dec_legal = 1'b0;
    endcase
    if (!dec_legal) begin
      dec_code = 5'b00000;
      dec_size = 2'b00;
    end
  end

  always_comb begin
    state_d    = state_q;
    alu_code_d = alu_code_q;
    mem_size_d = mem_size_q;
    case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        state_d    = dec_legal ? dec_state : (TRAP_ON_ILLEGAL ? StTrap : StFetch);
        alu_code_d = dec_code;
        mem_size_d = dec_size;
      end
      StExecR, StExecI, StExecU:                 state_d = StWb;
      StWb, StWbLd, StBrTaken, StJump, StTrap:   state_d = StFetch;
      StAddr:   state_d = instruction[5] ? StMemWr : StMemRd;
      StMemRd:  if (mem_ready) state_d = StWbLd;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StBranch: state_d = bcond ? StBrTaken : StFetch;
      StLink:   state_d = StJump;
`ifdef CNTL_MC_MULDIV_EN
      StMulDiv: if (md_done) state_d = StWb;
`endif
      default:  state_d = StFetch;
    endcase
  end

  // Trap exit, NOP-style illegal skip and fetch stalls do not retire anything.
  assign retire    = (state_d == StFetch) && (state_q != StFetch) &&
                     (state_q != StDecode) && (state_q != StTrap);
  assign instret_d = retire ? instret_q + CNT_WIDTH'(1) : instret_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StFetch;
      alu_code_q <= '0;
      mem_size_q <= '0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      alu_code_q <= alu_code_d;
      mem_size_q <= mem_size_d;
      instret_q  <= instret_d;
    end
  end

`ifdef CNTL_MC_MULDIV_EN
  logic md_started_q, md_started_d;
  assign md_started_d = (state_q == StMulDiv) && (state_d == StMulDiv);
  always_ff @(posedge clk) begin
    if (!rst) md_started_q <= 1'b0;
    else      md_started_q <= md_started_d;
  end
`else
  logic unused_md_done;
  assign unused_md_done = md_done;
`endif

  always_comb begin
    i_d_mem    = 1'b0;
    mem_r      = 1'b0;
    mem_w      = 1'b0;
    op1_sel    = 1'b0;
    op2_sel    = 2'b00;
    alu_demux  = 2'b00;
    wr_reg_mux = 1'b0;
    wr_en      = 1'b0;
    load_ir    = 1'b0;
    pc_update  = 1'b0;
    load_mdr   = 1'b0;
    md_start   = 1'b0;
    trap       = 1'b0;
    case (state_q)
      StFetch: begin
        mem_r     = 1'b1;
        op2_sel   = 2'b10;
        load_ir   = mem_ready;
        pc_update = mem_ready;
      end
      StExecR: begin
        op1_sel   = 1'b1;
        alu_demux = 2'b01;
      end
      StExecI: begin
        op1_sel   = 1'b1;
        op2_sel   = 2'b01;
        alu_demux = 2'b01;
      end
      StExecU: begin
        op2_sel   = 2'b01;
        alu_demux = 2'b01;
      end
      StWb:     wr_en = 1'b1;
      StAddr: begin
        op1_sel   = 1'b1;
        op2_sel   = 2'b01;
        alu_demux = 2'b10;
      end
      StMemRd: begin
        i_d_mem  = 1'b1;
        mem_r    = 1'b1;
        load_mdr = mem_ready;
      end
      StWbLd: begin
        wr_en      = 1'b1;
        wr_reg_mux = 1'b1;
      end
      StMemWr: begin
        i_d_mem = 1'b1;
        mem_w   = 1'b1;
      end
      StBranch: op1_sel = 1'b1;
      StBrTaken: begin
        op2_sel   = 2'b01;
        pc_update = 1'b1;
      end
      StLink: begin
        op2_sel   = 2'b10;
        alu_demux = 2'b01;
      end
      StJump: begin
        wr_en     = 1'b1;
        op1_sel   = ~instruction[3];  // JALR targets rs1+imm, JAL targets PC+imm
        op2_sel   = 2'b01;
        pc_update = 1'b1;
      end
      StTrap:   trap = 1'b1;
`ifdef CNTL_MC_MULDIV_EN
      StMulDiv: begin
        md_start  = ~md_started_q;
        op1_sel   = 1'b1;
        alu_demux = 2'b01;
      end
`endif
      default: ;
    endcase
    if (!rst) begin
      i_d_mem    = 1'b0;
      mem_r      = 1'b0;
      mem_w      = 1'b0;
      op1_sel    = 1'b0;
      op2_sel    = 2'b00;
      alu_demux  = 2'b00;
      wr_reg_mux = 1'b0;
      wr_en      = 1'b0;
      load_ir    = 1'b0;
      pc_update  = 1'b0;
      load_mdr   = 1'b0;
      md_start   = 1'b0;
      trap       = 1'b0;
    end
  end

  assign alu_ctrl = rst ? ALU_CTRL_WIDTH'(alu_code_q) : '0;
  assign mem_size = rst ? mem_size_q : 2'b00;
  assign instret  = rst ? instret_q : '0;

endmodule

// File: tb/tb_cntl_mc_param.sv
// Bench for cntl_mc_param: per-instruction expected cycle plans built from the latency and
// output tables, checked every cycle, plus literal spot checks on key values.
module tb_cntl_mc_param;
  localparam int unsigned AW  = 5;
  localparam int unsigned CW  = 32;
  localparam bit          TOI = 1'b1;

  localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011, OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_R = 7'b0110011, OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_BR = 7'b1100011, OPC_JAL = 7'b1101111, OPC_JALR = 7'b1100111;

  // Control word: {i_d_mem, mem_r, mem_w, op1, op2[1:0], demux[1:0], wr_reg_mux, wr_en,
  //                load_ir, pc_update, load_mdr, md_start, trap}
  localparam logic [14:0] IDM = 15'h4000, MR = 15'h2000, MW = 15'h1000, O1 = 15'h0800;
  localparam logic [14:0] O2_4 = 15'h0400, O2_IMM = 15'h0200, DM_MAR = 15'h0100;
  localparam logic [14:0] DM_ALU = 15'h0080, WRM = 15'h0040, WE = 15'h0020, LIR = 15'h0010;
  localparam logic [14:0] PCU = 15'h0008, LMD = 15'h0004, MDS = 15'h0002, TRP = 15'h0001;

  logic          clk = 1'b0, rst = 1'b0;
  logic [31:0]   instruction = 32'h0;
  logic          bcond = 1'b0, mem_ready = 1'b0, md_done = 1'b0;
  logic          i_d_mem, mem_r, mem_w, op1_sel, wr_reg_mux, wr_en, load_ir, pc_update;
  logic          load_mdr, md_start, trap;
  logic [1:0]    op2_sel, alu_demux, mem_size;
  logic [AW-1:0] alu_ctrl;
  logic [CW-1:0] instret;

  cntl_mc_param #(.ALU_CTRL_WIDTH(AW), .CNT_WIDTH(CW), .TRAP_ON_ILLEGAL(TOI)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .bcond(bcond), .mem_ready(mem_ready),
    .md_done(md_done), .i_d_mem(i_d_mem), .mem_r(mem_r), .mem_w(mem_w), .op1_sel(op1_sel),
    .op2_sel(op2_sel), .alu_demux(alu_demux), .wr_reg_mux(wr_reg_mux), .wr_en(wr_en),
    .load_ir(load_ir), .pc_update(pc_update), .load_mdr(load_mdr), .alu_ctrl(alu_ctrl),
    .mem_size(mem_size), .md_start(md_start), .trap(trap), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mr;
    logic        bc;
    logic        mdd;
    logic [14:0] ctrl;
    logic        alu_ok;
    logic [4:0]  alu;
    logic [1:0]  size;
    logic [31:0] cnt;
  } rec_t;

  rec_t        plan[$];
  rec_t        cur;
  logic        chk_en = 1'b0;
  int          n_checks = 0, n_errors = 0, rd_cnt = 0, mds_cnt = 0;
  logic [4:0]  m_alu = 5'd0;
  logic [1:0]  m_size = 2'd0;
  logic        m_alu_ok = 1'b1;
  logic [31:0] m_cnt = 32'd0;
  logic [14:0] act_ctrl;

  assign act_ctrl = {i_d_mem, mem_r, mem_w, op1_sel, op2_sel, alu_demux, wr_reg_mux, wr_en,
                     load_ir, pc_update, load_mdr, md_start, trap};

  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (act_ctrl !== cur.ctrl) begin
        n_errors++;
        $display("FAIL ctrl @%0t: got %b want %b", $time, act_ctrl, cur.ctrl);
      end
      n_checks++;
      if (instret !== cur.cnt) begin
        n_errors++;
        $display("FAIL instret @%0t: got %0d want %0d", $time, instret, cur.cnt);
      end
      n_checks++;
      if (mem_size !== cur.size) begin
        n_errors++;
        $display("FAIL mem_size @%0t: got %b want %b", $time, mem_size, cur.size);
      end
      if (cur.alu_ok) begin
        n_checks++;
        if (alu_ctrl !== cur.alu) begin
          n_errors++;
          $display("FAIL alu_ctrl @%0t: got %b want %b", $time, alu_ctrl, cur.alu);
        end
      end
      if (i_d_mem && mem_r) rd_cnt++;
      if (md_start) mds_cnt++;
    end
  end

  function automatic logic [4:0] exp_alu(input logic [31:0] ins, input bit md);
    logic [2:0] f3;
    f3 = ins[14:12];
    if (md) return 5'b00000;
    case (ins[6:0])
      OPC_R:   return {1'b0, ins[30], f3};
      OPC_I: begin
        if (f3 == 3'b010 || f3 == 3'b011) return {2'b01, f3};
        if (f3 == 3'b101) return {1'b0, ins[30], f3};
        return {2'b00, f3};
      end
      OPC_BR:  return {2'b10, f3};
      OPC_LUI: return 5'b11000;
      default: return 5'b00000;
    endcase
  endfunction

  task automatic add(input logic mr, input logic bc, input logic mdd, input logic [14:0] c);
    rec_t r;
    r.mr = mr; r.bc = bc; r.mdd = mdd; r.ctrl = c;
    r.alu_ok = m_alu_ok; r.alu = m_alu; r.size = m_size; r.cnt = m_cnt;
    plan.push_back(r);
  endtask

  task automatic build(input logic [31:0] ins, input int fw, input int mw, input logic bc,
                       input int mdlat);
    logic [6:0] opc;
    bit         legal, md;
    opc   = ins[6:0];
    md    = (opc == OPC_R) && (ins[31:25] == 7'b0000001);
    legal = opc inside {OPC_LOAD, OPC_STORE, OPC_I, OPC_R, OPC_LUI, OPC_AUIPC, OPC_BR,
                        OPC_JAL, OPC_JALR};
`ifndef CNTL_MC_MULDIV_EN
    if (md) legal = 1'b0;
`endif
    plan.delete();
    for (int i = 0; i < fw; i++) add(1'b0, 1'b0, 1'b0, MR | O2_4);
    add(1'b1, 1'b0, 1'b0, MR | O2_4 | LIR | PCU);
    add(1'b1, 1'b0, 1'b0, 15'h0);
    m_alu_ok = legal;
    m_alu    = legal ? exp_alu(ins, md) : 5'd0;
    m_size   = (legal && (opc == OPC_LOAD || opc == OPC_STORE)) ? ins[13:12] : 2'b00;
    if (!legal) begin
      if (TOI) add(1'b1, 1'b0, 1'b0, TRP);
    end else if (md) begin
      for (int k = 0; k < mdlat; k++)
        add(1'b1, 1'b0, (k == mdlat - 1), O1 | DM_ALU | ((k == 0) ? MDS : 15'h0));
      add(1'b1, 1'b0, 1'b0, WE);
    end else begin
      case (opc)
        OPC_R:   begin add(1'b1, 1'b0, 1'b0, O1 | DM_ALU); add(1'b1, 1'b0, 1'b0, WE); end
        OPC_I:   begin add(1'b1, 1'b0, 1'b0, O1 | O2_IMM | DM_ALU); add(1'b1, 1'b0, 1'b0, WE); end
        OPC_LUI, OPC_AUIPC: begin
          add(1'b1, 1'b0, 1'b0, O2_IMM | DM_ALU);
          add(1'b1, 1'b0, 1'b0, WE);
        end
        OPC_LOAD: begin
          add(1'b1, 1'b0, 1'b0, O1 | O2_IMM | DM_MAR);
          for (int i = 0; i < mw; i++) add(1'b0, 1'b0, 1'b0, IDM | MR);
          add(1'b1, 1'b0, 1'b0, IDM | MR | LMD);
          add(1'b1, 1'b0, 1'b0, WE | WRM);
        end
        OPC_STORE: begin
          add(1'b1, 1'b0, 1'b0, O1 | O2_IMM | DM_MAR);
          for (int i = 0; i < mw; i++) add(1'b0, 1'b0, 1'b0, IDM | MW);
          add(1'b1, 1'b0, 1'b0, IDM | MW);
        end
        OPC_BR: begin
          add(1'b1, bc, 1'b0, O1);
          if (bc) add(1'b1, 1'b0, 1'b0, O2_IMM | PCU);
        end
        default: begin
          add(1'b1, 1'b0, 1'b0, O2_4 | DM_ALU);
          add(1'b1, 1'b0, 1'b0, WE | O2_IMM | PCU | ((opc == OPC_JALR) ? O1 : 15'h0));
        end
      endcase
    end
    if (legal) m_cnt++;
  endtask

  task automatic step(input rec_t r, input bit rst_val, input bit load, input logic [31:0] ins);
    @(posedge clk);
    #1;
    rst = rst_val;
    if (load) instruction = ins;
    mem_ready = r.mr;
    bcond     = r.bc;
    md_done   = r.mdd;
    cur       = r;
    chk_en    = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic run(input logic [31:0] ins, input int fw, input int mw, input logic bc,
                     input int mdlat, input int n_exec);
    build(ins, fw, mw, bc, mdlat);
    for (int i = 0; i < plan.size() && (n_exec < 0 || i < n_exec); i++)
      step(plan[i], 1'b1, (i == 0), ins);
  endtask

  task automatic do_reset(input int n);
    rec_t r;
    r = '0;
    r.mr = 1'b1;
    r.alu_ok = 1'b1;
    for (int i = 0; i < n; i++) step(r, 1'b0, 1'b0, 32'h0);
    m_alu = 5'd0; m_size = 2'd0; m_alu_ok = 1'b1; m_cnt = 32'd0;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset(2);
    lit("reset instret", instret, 32'd0);
    lit("reset mem_r", 32'(mem_r), 32'd0);

    run(32'h002081B3, 0, 0, 1'b0, 0, -1);               // ADD
    lit("add wr_en", 32'(wr_en), 32'd1);
    lit("add alu_ctrl", 32'(alu_ctrl), 32'h00);
    run(32'h402081B3, 0, 0, 1'b0, 0, -1);               // SUB
    lit("sub alu_ctrl", 32'(alu_ctrl), 32'h08);
    run(32'h4030D193, 0, 0, 1'b0, 0, -1);               // SRAI
    lit("srai alu_ctrl", 32'(alu_ctrl), 32'h0D);
    lit("instret after add/sub", instret, 32'd2);

    rd_cnt = 0;
    run(32'h0000A183, 0, 3, 1'b0, 0, -1);               // LW, 3 wait cycles
    lit("lw data read cycles", rd_cnt, 32'd4);
    lit("lw mem_size", 32'(mem_size), 32'd2);
    lit("lw wr_reg_mux", 32'(wr_reg_mux), 32'd1);

    run(32'h00208463, 0, 0, 1'b0, 0, -1);               // BEQ not taken
    lit("beq nt pc_update", 32'(pc_update), 32'd0);
    run(32'h00208463, 0, 0, 1'b1, 0, -1);               // BEQ taken
    lit("beq t pc_update", 32'(pc_update), 32'd1);
    lit("beq alu_ctrl", 32'(alu_ctrl), 32'h10);

    run(32'h123450B7, 0, 0, 1'b0, 0, -1);               // LUI
    lit("lui alu_ctrl", 32'(alu_ctrl), 32'h18);
    run(32'h00001097, 0, 0, 1'b0, 0, -1);               // AUIPC
    run(32'h00508093, 2, 0, 1'b0, 0, -1);               // ADDI, 2 fetch waits
    run(32'h0050A093, 0, 0, 1'b0, 0, -1);               // SLTI
    lit("slti alu_ctrl", 32'(alu_ctrl), 32'h0A);
    run(32'h0030A023, 0, 2, 1'b0, 0, -1);               // SW, 2 wait cycles
    run(32'h008000EF, 0, 0, 1'b0, 0, -1);               // JAL
    lit("jal op1_sel", 32'(op1_sel), 32'd0);
    run(32'h000080E7, 0, 0, 1'b0, 0, -1);               // JALR
    lit("jalr op1_sel", 32'(op1_sel), 32'd1);

    run(32'hFFFFFFFF, 0, 0, 1'b0, 0, -1);               // illegal opcode
    lit("illegal trap", 32'(trap), 32'd1);
    lit("illegal instret", instret, 32'd13);
    run(32'h002081B0, 0, 0, 1'b0, 0, -1);               // bad low bits

    mds_cnt = 0;
    run(32'h022081B3, 0, 0, 1'b0, 5, -1);               // MUL
`ifdef CNTL_MC_MULDIV_EN
    lit("mul md_start pulses", mds_cnt, 32'd1);
    lit("mul wb wr_en", 32'(wr_en), 32'd1);
`else
    lit("mul trap", 32'(trap), 32'd1);
    lit("mul md_start pulses", mds_cnt, 32'd0);
`endif

    run(32'h0030A023, 0, 5, 1'b0, 0, 4);                // SW aborted in MEM_WR
    lit("sw mem_w before reset", 32'(mem_w), 32'd1);
    do_reset(1);
    lit("abort mem_w", 32'(mem_w), 32'd0);
    lit("abort instret", instret, 32'd0);
    run(32'h002081B3, 0, 0, 1'b0, 0, -1);
    run(32'h002081B3, 0, 0, 1'b0, 0, -1);
    lit("instret after reset", instret, 32'd1);

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
